bus_slave: RTL and testbench
============================

BUS_SLAVE -- requirements
Module: bus_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words stored (power of two, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before each response (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port s_sel, input, 1, request from the bus; held high until s_ready.
REQ-006 SHALL have port s_wr, input, 1, 1 = write, 0 = read; stable while s_sel is high.
REQ-007 SHALL have port s_addr, input, 8, word address; stable while s_sel is high.
REQ-008 SHALL have port s_din, input, 32, write data; stable while s_sel is high.
REQ-009 SHALL have port s_dout, output, 32, read data, registered.
REQ-010 SHALL have port s_ready, output, 1, one-cycle response strobe, registered.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP, GAP.
REQ-012 IDLE: on s_sel=1, SHALL latch s_wr, s_addr and s_din, load wait counter with WAIT_CYCLES, and go to WAIT (or to RESP if WAIT_CYCLES=0).
REQ-013 WAIT: counter SHALL decrement each cycle; go to RESP in the cycle after the counter reaches 1.
REQ-014 RESP: s_ready SHALL be 1 for exactly one cycle; a write SHALL commit to memory in this cycle; for a read, s_dout SHALL present the addressed word in this cycle.
REQ-015 GAP: one cycle with s_ready=0; s_sel is ignored; then IDLE. Minimum spacing between s_ready pulses is WAIT_CYCLES+3 cycles.
REQ-016 Request-to-ready latency, measured from the first cycle s_sel=1 in IDLE, SHALL be WAIT_CYCLES+1 cycles.
REQ-017 s_dout SHALL hold the last read value until the next read response; writes SHALL NOT alter s_dout.
REQ-018 Word index SHALL be s_addr modulo DEPTH; an in-range address is s_addr < DEPTH.
REQ-019 Dropping s_sel before s_ready SHALL NOT abort the transaction; the latched request completes (protocol violation tolerated).
REQ-020 A read in RESP of a word written in an earlier RESP SHALL return the new value.

Reset
REQ-021 Reset SHALL force state IDLE, s_ready=0, s_dout=32'h0000_0000, wait counter 0, and any optional s_err output to 0, immediately and independently of clk.
REQ-022 Memory contents SHALL be cleared to 0 by reset.
REQ-023 Reset asserted mid-transaction SHALL abandon it with no memory write and no s_ready pulse.

Configuration
REQ-024 Macro BUS_SLAVE_ERR_EN defined: add output s_err (1 bit, registered). For an out-of-range address, s_err=1 in the RESP cycle together with s_ready, writes are discarded, and reads return 32'h0000_0000 on s_dout.
REQ-025 BUS_SLAVE_ERR_EN undefined: no s_err port; out-of-range addresses alias per REQ-018.

Structure
REQ-026 Shared package bus_pkg SHALL hold the FSM state encoding, the data width (32), and the address width (8).
REQ-027 Storage SHALL be a sub-module bus_slave_mem: synchronous write, combinational read, asynchronous clear.

Verification
REQ-028 Write-then-read test, with WAIT_CYCLES=1: write addr 8'h03 data 32'hAAAA_AAAA, then read addr 8'h03 -> each s_ready rises 2 cycles after s_sel; the read gives s_dout=32'hAAAA_AAAA.
REQ-029 Zero-wait test, with WAIT_CYCLES=0: read addr 8'h05 after reset -> s_ready 1 cycle after s_sel, s_dout=32'h0.
REQ-030 Back-to-back test: s_sel held high across two reads -> the second s_ready comes exactly WAIT_CYCLES+3 cycles after the first.
REQ-031 Mid-operation reset test: assert reset in WAIT during a write of 32'hFFFF_FFFF to addr 8'h01 -> no s_ready pulse; a later read of addr 8'h01 returns 32'h0.
REQ-032 Out-of-range test, with BUS_SLAVE_ERR_EN and DEPTH=16: write 32'h1234_5678 to addr 8'h12, then read addr 8'h02 -> s_err=1 on the write response; the read returns 32'h0 with s_err=0. Without the macro, the read of addr 8'h02 returns 32'h1234_5678.
REQ-033 s_dout retention test: read addr 8'h03 giving 32'hAAAA_AAAA, then write 32'h0 to addr 8'h04 -> s_dout stays 32'hAAAA_AAAA.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus_slave block: FSM state encoding,
// data width and word-address width.
package bus_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage : bus_pkg

// File: rtl/bus_slave_if.sv
// Request/response bus between a master and bus_slave.
// s_err exists only when BUS_SLAVE_ERR_EN is defined.
interface bus_slave_if;
  import bus_pkg::*;

  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_ready;
`ifdef BUS_SLAVE_ERR_EN
  logic              s_err;

  modport master (output s_sel, s_wr, s_addr, s_din, input s_dout, s_ready, s_err);
  modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout, s_ready, s_err);
`else
  modport master (output s_sel, s_wr, s_addr, s_din, input s_dout, s_ready);
  modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout, s_ready);
`endif

endinterface : bus_slave_if

// File: rtl/bus_slave_mem.sv
// Word storage for bus_slave: synchronous write, combinational read,
// whole array cleared asynchronously by reset.
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array must clear on reset, so it maps to resettable flops
  // rather than a RAM macro (RAM macros have no reset port).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : bus_slave_mem

// File: rtl/bus_slave.sv
// Wait-state bus slave over a DEPTH-word memory; one s_ready strobe per request.
// Optional out-of-range error reporting via macro BUS_SLAVE_ERR_EN.
module bus_slave
  import bus_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        reset,
  bus_slave_if.slave s_bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) % DEPTH);
  endfunction

`ifdef BUS_SLAVE_ERR_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return 32'(a) >= 32'(DEPTH);
  endfunction
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  // In IDLE the request is still on the bus; later it lives in the latches.
  assign req_wr   = (state_q == IDLE) ? s_bus.s_wr   : wr_q;
  assign req_addr = (state_q == IDLE) ? s_bus.s_addr : addr_q;

`ifdef BUS_SLAVE_ERR_EN
  assign mem_we = (state_q == RESP) && wr_q && !out_of_range(addr_q);
`else
  assign mem_we = (state_q == RESP) && wr_q;
`endif

  bus_slave_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (word_idx(addr_q)),
    .wdata_i (din_q),
    .raddr_i (word_idx(req_addr)),
    .rdata_o (rd_data)
  );

  always_comb begin
    // NOTE: every variable gets its default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_bus.s_sel) begin
          wr_d    = s_bus.s_wr;
          addr_d  = s_bus.s_addr;
          din_d   = s_bus.s_din;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response outputs are registered, so they are computed on entry to RESP.
    ready_d = (state_d == RESP);
`ifdef BUS_SLAVE_ERR_EN
    err_d = ready_d && out_of_range(req_addr);
    if (ready_d && !req_wr) dout_d = out_of_range(req_addr) ? '0 : rd_data;
`else
    if (ready_d && !req_wr) dout_d = rd_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and updates together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign s_bus.s_dout  = dout_q;
  assign s_bus.s_ready = ready_q;
`ifdef BUS_SLAVE_ERR_EN
  assign s_bus.s_err   = err_q;
`endif

endmodule : bus_slave

// File: tb/tb_bus_slave.sv
// Self-checking bench for bus_slave: three instances (WAIT_CYCLES 1/0/3)
// checked against a word-array reference model kept in the bench.
module tb_bus_slave;
  import bus_pkg::*;

  function automatic int wc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int depth_of(input int k);
    return (k == 2) ? 32 : 16;
  endfunction

  logic              clk;
  logic              rst    [3];
  logic              sel    [3];
  logic              wr     [3];
  logic [ADDR_W-1:0] addr   [3];
  logic [DATA_W-1:0] din    [3];
  logic              ready  [3];
  logic [DATA_W-1:0] dout   [3];
  logic              err    [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word arrays plus the last read value per instance.
  logic [DATA_W-1:0] mem_m    [3][256];
  logic [DATA_W-1:0] exp_dout [3];
  logic              exp_err  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = wc_of(g);
    localparam int D = depth_of(g);
    bus_slave_if u_if ();
    assign u_if.s_sel  = sel[g];
    assign u_if.s_wr   = wr[g];
    assign u_if.s_addr = addr[g];
    assign u_if.s_din  = din[g];
    assign ready[g]    = u_if.s_ready;
    assign dout[g]     = u_if.s_dout;
`ifdef BUS_SLAVE_ERR_EN
    assign err[g]      = u_if.s_err;
`else
    assign err[g]      = 1'b0;
`endif
    bus_slave #(.DEPTH(D), .WAIT_CYCLES(W)) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .s_bus (u_if.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset(input int k);
    for (int i = 0; i < 256; i++) mem_m[k][i] = '0;
    exp_dout[k] = '0;
    exp_err[k]  = 1'b0;
  endtask

  task automatic model_apply(input int k, input logic w, input logic [7:0] a, input logic [31:0] d);
    int  idx;
    bit  oor;
    idx = int'(a) % depth_of(k);
    oor = int'(a) >= depth_of(k);
`ifdef BUS_SLAVE_ERR_EN
    exp_err[k] = oor;
    if (w) begin
      if (!oor) mem_m[k][idx] = d;
    end else begin
      exp_dout[k] = oor ? 32'h0 : mem_m[k][idx];
    end
`else
    exp_err[k] = 1'b0;
    if (oor) idx = idx;
    if (w) mem_m[k][idx] = d;
    else   exp_dout[k] = mem_m[k][idx];
`endif
  endtask

  // One request, s_sel held until s_ready; returns latency (-1 on timeout),
  // outputs seen in the s_ready cycle, and s_ready one cycle later.
  task automatic bus_txn(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] o_dout, output logic o_err,
                         output logic o_gap);
    @(negedge clk);
    sel[k] = 1'b1; wr[k] = w; addr[k] = a; din[k] = d;
    lat = -1;
    for (int c = 1; c <= 64 && lat < 0; c++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) lat = c;
    end
    o_dout = dout[k];
    o_err  = err[k];
    sel[k] = 1'b0;
    @(negedge clk);
    o_gap = ready[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; sel[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    #1;  // before any clock edge: reset must act asynchronously
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ready[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready[k]); end
      n_tests++;
      if (dout[k] !== 32'h0) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 0", k, dout[k]); end
      n_tests++;
      if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err[k]); end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      model_reset(k);
    end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] od; logic oe, og;
    bus_txn(1, 1'b0, 8'h05, 32'h0, lat, od, oe, og);
    model_apply(1, 1'b0, 8'h05, 32'h0);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL zero_wait_latency: got %0d expected 1", lat); end
    n_tests++;
    if (od !== 32'h0) begin n_fail++; $display("FAIL zero_wait_dout: got %h expected 0", od); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] od; logic oe, og;
    bus_txn(0, 1'b1, 8'h03, 32'hAAAA_AAAA, lat, od, oe, og);
    model_apply(0, 1'b1, 8'h03, 32'hAAAA_AAAA);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    n_tests++;
    if (og !== 1'b0) begin n_fail++; $display("FAIL wr_ready_width: got %b expected 0", og); end
    bus_txn(0, 1'b0, 8'h03, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h03, 32'h0);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    n_tests++;
    if (od !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL rd_dout: got %h expected aaaaaaaa", od); end
  endtask

  task automatic test_retention();
    int lat; logic [31:0] od; logic oe, og;
    bus_txn(0, 1'b0, 8'h03, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h03, 32'h0);
    n_tests++;
    if (od !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL retain_read: got %h expected aaaaaaaa", od); end
    bus_txn(0, 1'b1, 8'h04, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b1, 8'h04, 32'h0);
    n_tests++;
    if (od !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL retain_after_write: got %h expected aaaaaaaa", od); end
  endtask

  task automatic test_back_to_back(input int k, input logic [7:0] a);
    int t1, t2;
    logic [31:0] od;
    t1 = -1; t2 = -1;
    @(negedge clk);
    sel[k] = 1'b1; wr[k] = 1'b0; addr[k] = a; din[k] = '0;
    for (int c = 1; c <= 100 && t2 < 0; c++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        if (t1 < 0) t1 = c;
        else        t2 = c;
      end
    end
    od = dout[k];
    sel[k] = 1'b0;
    @(negedge clk);
    model_apply(k, 1'b0, a, 32'h0);
    model_apply(k, 1'b0, a, 32'h0);
    n_tests++;
    if (t1 !== wc_of(k) + 1) begin n_fail++; $display("FAIL b2b_first[%0d]: got %0d expected %0d", k, t1, wc_of(k) + 1); end
    n_tests++;
    if (t2 - t1 !== wc_of(k) + 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, t2 - t1, wc_of(k) + 3); end
    n_tests++;
    if (od !== exp_dout[k]) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %h expected %h", k, od, exp_dout[k]); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] od; logic oe, og;
    logic        wr_err_exp;
    logic [31:0] rd_exp;
`ifdef BUS_SLAVE_ERR_EN
    wr_err_exp = 1'b1; rd_exp = 32'h0;
`else
    wr_err_exp = 1'b0; rd_exp = 32'h1234_5678;
`endif
    bus_txn(0, 1'b1, 8'h12, 32'h1234_5678, lat, od, oe, og);
    model_apply(0, 1'b1, 8'h12, 32'h1234_5678);
    n_tests++;
    if (oe !== wr_err_exp) begin n_fail++; $display("FAIL oor_write_err: got %b expected %b", oe, wr_err_exp); end
    bus_txn(0, 1'b0, 8'h02, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h02, 32'h0);
    n_tests++;
    if (od !== rd_exp) begin n_fail++; $display("FAIL oor_alias_read: got %h expected %h", od, rd_exp); end
    n_tests++;
    if (oe !== 1'b0) begin n_fail++; $display("FAIL oor_read_err: got %b expected 0", oe); end
  endtask

  task automatic test_mid_reset();
    int lat, pulses; logic [31:0] od; logic oe, og;
    bus_txn(0, 1'b0, 8'h03, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h03, 32'h0);
    n_tests++;
    if (od !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL midrst_preread: got %h expected aaaaaaaa", od); end
    @(negedge clk);
    sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h01; din[0] = 32'hFFFF_FFFF;
    @(negedge clk);  // request latched, now waiting
    #1 rst[0] = 1'b1;
    #1;
    n_tests++;
    if (dout[0] !== 32'h0) begin n_fail++; $display("FAIL midrst_async_dout: got %h expected 0", dout[0]); end
    sel[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[0] === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_ready: got %0d pulses expected 0", pulses); end
    bus_txn(0, 1'b0, 8'h01, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h01, 32'h0);
    n_tests++;
    if (od !== 32'h0) begin n_fail++; $display("FAIL midrst_addr1: got %h expected 0", od); end
    bus_txn(0, 1'b0, 8'h03, 32'h0, lat, od, oe, og);
    model_apply(0, 1'b0, 8'h03, 32'h0);
    n_tests++;
    if (od !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_cleared: got %h expected 0", od); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] od; logic oe, og;
    logic w; logic [7:0] a; logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        w = 1'($urandom_range(1, 0));
        a = 8'($urandom_range(47, 0));
        d = $urandom;
        bus_txn(k, w, a, d, lat, od, oe, og);
        model_apply(k, w, a, d);
        n_tests++;
        if (lat !== wc_of(k) + 1) begin n_fail++; $display("FAIL rnd_latency[%0d.%0d]: got %0d expected %0d", k, n, lat, wc_of(k) + 1); end
        n_tests++;
        if (og !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_width[%0d.%0d]: got %b expected 0", k, n, og); end
        n_tests++;
        if (od !== exp_dout[k]) begin n_fail++; $display("FAIL rnd_dout[%0d.%0d] a=%h w=%b: got %h expected %h", k, n, a, w, od, exp_dout[k]); end
        n_tests++;
        if (oe !== exp_err[k]) begin n_fail++; $display("FAIL rnd_err[%0d.%0d] a=%h: got %b expected %b", k, n, a, oe, exp_err[k]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_write_read();
    test_retention();
    test_back_to_back(0, 8'h03);
    test_back_to_back(2, 8'($urandom_range(31, 0)));
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bus_slave
